// File: rtl/decrypt_depacker_pkg.sv
// Shared types for the byte-to-word depacker: lane count, keep-mask type and
// the packed word stored in the output FIFO.
// Optional feature macro: DEPACK_PARITY_EN adds a per-lane parity field to the
// stored word (40-bit FIFO entry instead of 36-bit).
package encrypt_config;

  localparam int WORD_BYTES = 4;
  localparam int DATA_W     = WORD_BYTES * 8;

  typedef logic [WORD_BYTES-1:0] keep_t;

  // Field order puts data in the low bits so the FIFO entry reads data-first.
  typedef struct packed {
`ifdef DEPACK_PARITY_EN
    keep_t             par;
`endif
    keep_t             keep;
    logic [DATA_W-1:0] data;
  } word_t;

  localparam int WORD_W = $bits(word_t);

  // Lane mask for a word holding 'cnt' bytes (0..4), lowest lanes first.
  function automatic keep_t keep_from_count(input logic [2:0] cnt);
    keep_t k;
    case (cnt)
      3'd1:    k = 4'b0001;
      3'd2:    k = 4'b0011;
      3'd3:    k = 4'b0111;
      3'd4:    k = 4'b1111;
      default: k = 4'b0000;
    endcase
    return k;
  endfunction

`ifdef DEPACK_PARITY_EN
  // Even parity per byte lane; lanes that carry no byte report 0.
  function automatic keep_t lane_parity(input logic [DATA_W-1:0] data,
                                        input keep_t             keep);
    keep_t p;
    p = '0;
    for (int n = 0; n < WORD_BYTES; n++) begin
      p[n] = keep[n] & (^data[8*n +: 8]);
    end
    return p;
  endfunction
`endif

endpackage

// File: rtl/decrypt_depacker_fifo.sv
// depack_fifo: first-word-fall-through word FIFO for the depacker.
// The head entry is visible on rdata whenever valid is high; rdata reads 0
// while empty so the depacker outputs are clean after reset.
// A push is taken when there is room or when a pop frees a slot in the same
// cycle; push_ok tells the caller whether the word was kept.
module depack_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   push_ok,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == FULL_LVL);
  assign w_pop   = pop && !w_empty;
  assign w_push  = push && (!w_full || w_pop);

  assign push_ok = w_push;
  assign valid   = !w_empty;
  assign full    = w_full;
  assign level   = r_level;
  assign rdata   = w_empty ? '0 : r_mem[r_rd_ptr];

  // Storage: write the tail slot on an accepted push. When full with a
  // simultaneous pop the tail slot equals the departing head slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks net change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/decrypt_depacker.sv
// decrypt_depacker: packs the decrypted byte stream into 32-bit words
// (first byte in [7:0]) and queues them in a FWFT FIFO for the consumer.
// A flush emits a partially filled word with a matching keep mask.
// Words completed while the FIFO is full are dropped and flagged on the
// sticky overflow output.
// Optional feature macro: DEPACK_PARITY_EN adds dout_par (per-lane parity).
module decrypt_depacker
  import encrypt_config::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             din,
  input  logic                   din_v,
  input  logic                   flush,
  input  logic                   ovf_clr,
  output logic [31:0]            dout,
  output logic [3:0]             dout_keep,
  output logic                   dout_v,
  input  logic                   dout_rdy,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef DEPACK_PARITY_EN
  ,
  output logic [3:0]             dout_par
`endif
);

  logic [1:0]        r_byte_idx;
  logic [DATA_W-1:0] r_asm;
  logic              r_overflow;

  logic [DATA_W-1:0] w_asm_next;
  logic [2:0]        w_count;
  logic              w_push;
  logic              w_push_ok;
  logic              w_drop;
  logic              w_pop;
  logic              w_valid;
  word_t             w_wr_word;
  word_t             w_rd_word;
  logic [WORD_W-1:0] w_rd_bits;

  // Byte count including this cycle's byte; 4 means a complete word.
  assign w_count = {1'b0, r_byte_idx} + {2'b00, din_v};

  // Drop the incoming byte into its lane; the flush path sees it too.
  always_comb begin
    w_asm_next = r_asm;
    if (din_v) begin
      w_asm_next[8*r_byte_idx +: 8] = din;
    end
  end

  assign w_push = (w_count == 3'd4) || (flush && (w_count != 3'd0));

  // Unused lanes are already zero because the assembly register is cleared
  // after every push.
  always_comb begin
    w_wr_word      = '0;
    w_wr_word.data = w_asm_next;
    w_wr_word.keep = keep_from_count(w_count);
`ifdef DEPACK_PARITY_EN
    w_wr_word.par  = lane_parity(w_asm_next, keep_from_count(w_count));
`endif
  end

  assign w_pop  = w_valid && dout_rdy;
  assign w_drop = w_push && !w_push_ok;

  depack_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wdata   (w_wr_word),
    .push_ok (w_push_ok),
    .pop     (w_pop),
    .rdata   (w_rd_bits),
    .valid   (w_valid),
    .full    (full),
    .level   (level)
  );

  // Assembly register and lane index; both restart after any push, even a
  // dropped one, so the next byte always starts a fresh word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_idx <= '0;
      r_asm      <= '0;
    end else if (w_push) begin
      r_byte_idx <= '0;
      r_asm      <= '0;
    end else begin
      r_byte_idx <= w_count[1:0];
      r_asm      <= w_asm_next;
    end
  end

  // Sticky overflow: a drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign w_rd_word = w_rd_bits;
  assign dout      = w_rd_word.data;
  assign dout_keep = w_rd_word.keep;
  assign dout_v    = w_valid;
  assign overflow  = r_overflow;
`ifdef DEPACK_PARITY_EN
  assign dout_par  = w_rd_word.par;
`endif

endmodule

// File: tb/tb_decrypt_depacker.sv
// Directed bench for decrypt_depacker (DEPTH=4). Inputs change 1 ns after the
// rising edge and outputs are sampled there too, away from the active edge.
module tb_decrypt_depacker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  din = '0;
  logic        din_v = 1'b0;
  logic        flush = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] dout;
  logic [3:0]  dout_keep;
  logic        dout_v;
  logic        dout_rdy = 1'b0;
  logic        full;
  logic [$clog2(DEPTH):0] level;
  logic        overflow;
`ifdef DEPACK_PARITY_EN
  logic [3:0]  dout_par;
`endif

  int checks   = 0;
  int failures = 0;

  decrypt_depacker #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_v     (din_v),
    .flush     (flush),
    .ovf_clr   (ovf_clr),
    .dout      (dout),
    .dout_keep (dout_keep),
    .dout_v    (dout_v),
    .dout_rdy  (dout_rdy),
    .full      (full),
    .level     (level),
    .overflow  (overflow)
`ifdef DEPACK_PARITY_EN
    ,
    .dout_par  (dout_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    din   = b;
    din_v = 1'b1;
    step();
    din_v = 1'b0;
    din   = '0;
  endtask

  // Word i carries bytes i*16+1 .. i*16+4 in arrival order.
  function automatic logic [7:0] byte_of(input int i, input int k);
    return 8'(i*16 + k + 1);
  endfunction

  function automatic logic [31:0] word_of(input int i);
    return {byte_of(i, 3), byte_of(i, 2), byte_of(i, 1), byte_of(i, 0)};
  endfunction

  task automatic send_word(input int i);
    for (int k = 0; k < 4; k++) send_byte(byte_of(i, k));
  endtask

  initial begin
    int exp_order [4];

    // Reset state, held across clock edges
    step();
    step();
    check_val("rst_dout", dout, 0);
    check_val("rst_keep", dout_keep, 0);
    check_val("rst_v", dout_v, 0);
    check_val("rst_full", full, 0);
    check_val("rst_level", level, 0);
    check_val("rst_ovf", overflow, 0);
`ifdef DEPACK_PARITY_EN
    check_val("rst_par", dout_par, 0);
`endif
    rst = 1'b1;
    step();

    // Basic full word, one-cycle latency, single-cycle valid
    dout_rdy = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check_val("w1_not_yet", dout_v, 0);
    send_byte(8'h44);
    check_val("w1_v", dout_v, 1);
    check_val("w1_dout", dout, 32'h44332211);
    check_val("w1_keep", dout_keep, 4'b1111);
    step();
    check_val("w1_v_drop", dout_v, 0);

    // Partial word by flush, then idle flush produces nothing
    send_byte(8'hAA);
    send_byte(8'hBB);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("fl_v", dout_v, 1);
    check_val("fl_dout", dout, 32'h0000BBAA);
    check_val("fl_keep", dout_keep, 4'b0011);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("fl_idle_v", dout_v, 0);
    check_val("fl_idle_level", level, 0);

    // Flush together with a byte: byte is included
    send_byte(8'hCC);
    din = 8'hDD; din_v = 1'b1; flush = 1'b1;
    step();
    din_v = 1'b0; flush = 1'b0;
    check_val("flb_dout", dout, 32'h0000DDCC);
    check_val("flb_keep", dout_keep, 4'b0011);
    step();

    // Flush with 4th byte yields exactly one full word
    dout_rdy = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    din = 8'h04; din_v = 1'b1; flush = 1'b1;
    step();
    din_v = 1'b0; flush = 1'b0;
    check_val("fl4_level", level, 1);
    check_val("fl4_keep", dout_keep, 4'b1111);
    check_val("fl4_dout", dout, 32'h04030201);
    dout_rdy = 1'b1;
    step();
    dout_rdy = 1'b0;
    check_val("fl4_empty", level, 0);

    // Fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) send_word(i);
    check_val("fill_full", full, 1);
    check_val("fill_level", level, DEPTH);
    check_val("fill_ovf", overflow, 0);
    send_word(4);
    check_val("ovf_set", overflow, 1);
    check_val("ovf_level", level, DEPTH);
    check_val("ovf_head", dout, word_of(0));
    check_val("ovf_headkeep", dout_keep, 4'b1111);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_val("ovf_clr", overflow, 0);

    // Drop coinciding with clear keeps overflow set
    for (int k = 0; k < 3; k++) send_byte(byte_of(6, k));
    din = byte_of(6, 3); din_v = 1'b1; ovf_clr = 1'b1;
    step();
    din_v = 1'b0; ovf_clr = 1'b0;
    check_val("ovf_vs_clr", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_val("ovf_clr2", overflow, 0);

    // Push and pop together while full
    for (int k = 0; k < 3; k++) send_byte(byte_of(5, k));
    din = byte_of(5, 3); din_v = 1'b1; dout_rdy = 1'b1;
    step();
    din_v = 1'b0; dout_rdy = 1'b0;
    check_val("pp_level", level, DEPTH);
    check_val("pp_ovf", overflow, 0);
    check_val("pp_head", dout, word_of(1));
    exp_order = '{1, 2, 3, 5};
    dout_rdy = 1'b1;
    for (int n = 0; n < 4; n++) begin
      check_val($sformatf("drain%0d_v", n), dout_v, 1);
      check_val($sformatf("drain%0d", n), dout, word_of(exp_order[n]));
      step();
    end
    check_val("drain_empty", level, 0);
    check_val("drain_v", dout_v, 0);

    // Asynchronous reset with queued words and a partial word
    dout_rdy = 1'b0;
    send_word(7);
    send_word(8);
    send_byte(8'h55);
    send_byte(8'h66);
    check_val("pre_rst_level", level, 2);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_dout", dout, 0);
    check_val("arst_keep", dout_keep, 0);
    check_val("arst_v", dout_v, 0);
    check_val("arst_level", level, 0);
    check_val("arst_full", full, 0);
    check_val("arst_ovf", overflow, 0);
    #2;
    rst = 1'b1;
    step();
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h07);
    send_byte(8'hFF);
    check_val("post_rst_v", dout_v, 1);
    check_val("post_rst_dout", dout, 32'hFF070301);
    check_val("post_rst_level", level, 1);
`ifdef DEPACK_PARITY_EN
    check_val("par", dout_par, 4'b0101);
`endif
    dout_rdy = 1'b1;
    step();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check_val("rst_seq_dout", dout, 32'h04030201);
    check_val("rst_seq_keep", dout_keep, 4'b1111);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
